// File: rtl/clkdiv_monitor.sv
// clkdiv_monitor: windowed BIST checker for the divide-by-2/4/8/16 outputs.
// Counts rises and high samples of each channel over WINDOW_CYCLES clocks,
// checks every rise-to-rise interval, and reports per-channel error bits.
module clkdiv_monitor #(
  parameter int WINDOW_CYCLES = 160,
  parameter int DUTY_TOL      = 2,
  parameter int CNT_W         = $clog2(WINDOW_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] div_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_ratio,
  output logic [3:0] err_duty,
  output logic [3:0] err_period
);

  localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(WINDOW_CYCLES);
  localparam logic [CNT_W-1:0] HIGH_LO  = CNT_W'(WINDOW_CYCLES / 2 - DUTY_TOL);
  localparam logic [CNT_W-1:0] HIGH_HI  = CNT_W'(WINDOW_CYCLES / 2 + DUTY_TOL);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_REPORT  = 2'd2
  } state_t;

  // Ideal rise count of channel k over one window.
  function automatic logic [CNT_W-1:0] ideal_edges(input int k);
    return CNT_W'(WINDOW_CYCLES >> (k + 1));
  endfunction

  // Ideal rise-to-rise interval of channel k, in clk cycles.
  function automatic logic [4:0] ideal_period(input int k);
    return 5'(2 << k);
  endfunction

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic [3:0]       r_d_q;
  logic [3:0]       r_d_prev;
  logic [3:0]       w_rise;
  logic [CNT_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_edges [0:3];
  logic [CNT_W-1:0] r_highs [0:3];
  logic [4:0]       r_since [0:3];
  logic [3:0]       r_first_seen;
  logic [3:0]       w_err_ratio;
  logic [3:0]       w_err_duty;

  assign w_rise = r_d_q & ~r_d_prev;

  // Next-state logic; start is only honoured while idle.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_MEASURE;
          w_accept     = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        if (r_win_cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          w_state_next = ST_REPORT;
        end else begin
          w_state_next = ST_MEASURE;
        end
      end
      ST_REPORT: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Per-channel ratio and duty verdicts from the final counter values.
  always_comb begin
    w_err_ratio = 4'b0000;
    w_err_duty  = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      w_err_ratio[k] = (r_edges[k] != ideal_edges(k));
      w_err_duty[k]  = (r_highs[k] < HIGH_LO) || (r_highs[k] > HIGH_HI);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Input pipeline, window counters, period tracking and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d_q        <= 4'b0000;
      r_d_prev     <= 4'b0000;
      r_win_cnt    <= '0;
      r_first_seen <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        r_edges[k] <= '0;
        r_highs[k] <= '0;
        r_since[k] <= 5'd0;
      end
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_ratio  <= 4'b0000;
      err_duty   <= 4'b0000;
      err_period <= 4'b0000;
    end else begin
      r_d_q    <= div_in;
      r_d_prev <= r_d_q;
      done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_win_cnt    <= WIN_LOAD;
            r_first_seen <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
              r_edges[k] <= '0;
              r_highs[k] <= '0;
              r_since[k] <= 5'd0;
            end
            pass       <= 1'b0;
            err_ratio  <= 4'b0000;
            err_duty   <= 4'b0000;
            err_period <= 4'b0000;
            busy       <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_MEASURE: begin
          r_win_cnt <= r_win_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          for (int k = 0; k < 4; k++) begin
            r_edges[k] <= r_edges[k] + {{(CNT_W-1){1'b0}}, w_rise[k]};
            r_highs[k] <= r_highs[k] + {{(CNT_W-1){1'b0}}, r_d_q[k]};
            if (w_rise[k]) begin
              // The very first rise only starts the interval timer.
              if (r_first_seen[k] && (r_since[k] != ideal_period(k))) begin
                err_period[k] <= 1'b1;
              end else begin
                err_period[k] <= err_period[k];
              end
              r_since[k]      <= 5'd1;
              r_first_seen[k] <= 1'b1;
            end else if (r_since[k] != 5'd31) begin
              r_since[k] <= r_since[k] + 5'd1;
            end else begin
              r_since[k] <= r_since[k];
            end
          end
        end
        ST_REPORT: begin
          err_ratio <= w_err_ratio;
          err_duty  <= w_err_duty;
          pass      <= ~|{w_err_ratio, w_err_duty, err_period};
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_monitor.sv
// tb_clkdiv_monitor: directed bench; div_in comes from a free-running counter
// model of the divider, optionally distorted to provoke each error class.
module tb_clkdiv_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] div_in;
  logic       busy, done, pass;
  logic [3:0] err_ratio, err_duty, err_period;

  logic [7:0] cnt = 8'd0;
  int         mode = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  clkdiv_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .div_in     (div_in),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_ratio  (err_ratio),
    .err_duty   (err_duty),
    .err_period (err_period)
  );

  always #5 clk = ~clk;

  // Ideal divider: bit k of a free-running counter is divide-by-2^(k+1).
  always @(posedge clk) cnt <= cnt + 8'd1;

  // Divider model with selectable faults.
  always_comb begin
    div_in = cnt[3:0];
    case (mode)
      1:       div_in[0] = 1'b0;
      2:       div_in[2] = (cnt[2:0] >= 3'd3);
      3:       div_in[3] = cnt[3] | (cnt == 8'd67);
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start; returns at the negedge after the sampling edge.
  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Watch 200 cycles after the start edge; optionally re-pulse start at cycle restart_at.
  task automatic watch(input int restart_at, output int lat, output int busy_cnt, output int ndone);
    lat      = 0;
    ndone    = 0;
    busy_cnt = busy ? 1 : 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      start = (n == restart_at);
      if (busy) busy_cnt++;
      if (done) begin
        ndone++;
        if (lat == 0) lat = n;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_results(input string tag, input logic [3:0] e_ratio,
                               input logic [3:0] e_duty, input logic [3:0] e_period,
                               input logic e_pass);
    check_eq({tag, "_ratio"},  {28'd0, err_ratio},  {28'd0, e_ratio});
    check_eq({tag, "_duty"},   {28'd0, err_duty},   {28'd0, e_duty});
    check_eq({tag, "_period"}, {28'd0, err_period}, {28'd0, e_period});
    check_eq({tag, "_pass"},   {31'd0, pass},       {31'd0, e_pass});
  endtask

  initial begin
    int lat, bcnt, nd, found;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_results("rst", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: ideal divider
    mode = 0;
    pulse_start();
    check_eq("t1_busy_start", {31'd0, busy}, 32'd1);
    watch(0, lat, bcnt, nd);
    check_eq("t1_latency", lat, 32'd161);
    check_eq("t1_busy_cycles", bcnt, 32'd161);
    check_eq("t1_ndone", nd, 32'd1);
    check_results("t1", 4'b0000, 4'b0000, 4'b0000, 1'b1);
    check_eq("t1_edges0", 32'(dut.r_edges[0]), 32'd80);
    check_eq("t1_edges1", 32'(dut.r_edges[1]), 32'd40);
    check_eq("t1_edges2", 32'(dut.r_edges[2]), 32'd20);
    check_eq("t1_edges3", 32'(dut.r_edges[3]), 32'd10);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("t1_highs%0d", k), 32'(dut.r_highs[k]), 32'd80);
    end

    // 2: divideby2 stuck at 0
    mode = 1;
    pulse_start();
    watch(0, lat, bcnt, nd);
    check_eq("t2_ndone", nd, 32'd1);
    check_results("t2", 4'b0001, 4'b0001, 4'b0000, 1'b0);

    // 3: divideby8 at 5 high / 3 low
    mode = 2;
    pulse_start();
    watch(0, lat, bcnt, nd);
    check_results("t3", 4'b0000, 4'b0100, 4'b0000, 1'b0);
    check_eq("t3_highs2", 32'(dut.r_highs[2]), 32'd100);

    // 4: one extra one-cycle pulse on divideby16 (at cnt==67, mid-window)
    mode = 3;
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      @(negedge clk);
      if (cnt == 8'd10) found = 1;
    end
    check_eq("t4_align", found, 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    watch(0, lat, bcnt, nd);
    check_results("t4", 4'b1000, 4'b0000, 4'b1000, 1'b0);
    check_eq("t4_edges3", 32'(dut.r_edges[3]), 32'd11);
    check_eq("t4_highs3", 32'(dut.r_highs[3]), 32'd81);

    // 5: start during an active window, and start on the done edge
    mode = 0;
    pulse_start();
    watch(50, lat, bcnt, nd);
    check_eq("t5a_latency", lat, 32'd161);
    check_eq("t5a_ndone", nd, 32'd1);
    pulse_start();
    watch(160, lat, bcnt, nd);
    check_eq("t5b_latency", lat, 32'd161);
    check_eq("t5b_ndone", nd, 32'd1);
    check_results("t5", 4'b0000, 4'b0000, 4'b0000, 1'b1);

    // 6: reset mid-window aborts; a following window passes
    mode = 2;
    pulse_start();
    repeat (70) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("t6_rst_busy", {31'd0, busy}, 32'd0);
    check_results("t6_rst", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    nd = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    rst = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check_eq("t6_no_done", nd, 32'd0);
    mode = 0;
    pulse_start();
    watch(0, lat, bcnt, nd);
    check_eq("t6_latency", lat, 32'd161);
    check_results("t6", 4'b0000, 4'b0000, 4'b0000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
